// File: rtl/cordic_vec_iter.sv
// cordic_vec_iter: iterative shift-add CORDIC, vectoring (magnitude + direction word) or rotation (apply a direction word).
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_valid_i/in_ready_o, mode_i (0 vectoring, 1 rotation), x_i, y_i, dir_i : operand handshake
//   out_valid_o/out_ready_i, x_o, y_o (saturated, gain-scaled), dir_o {pre-negate, d[ITER-1:0]} : result handshake
module cordic_vec_iter #(
    parameter int DATA_W = 17,
    parameter int ITER   = 12,
    parameter int GUARD  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     mode_i,
    input  logic signed [DATA_W-1:0] x_i,
    input  logic signed [DATA_W-1:0] y_i,
    input  logic [ITER:0]            dir_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic signed [DATA_W-1:0] x_o,
    output logic signed [DATA_W-1:0] y_o,
    output logic [ITER:0]            dir_o
);
    localparam int W  = DATA_W + GUARD;
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic signed [W-1:0] x_q, x_d, y_q, y_d;
    logic [ITER:0]       dir_q, dir_d;
    logic                mode_q, mode_d;
    logic signed [W-1:0] x_ext, y_ext, x_sh, y_sh;
    logic                pre, d;

    // Values outside the DATA_W range clamp to the nearest end instead of wrapping.
    function automatic logic signed [DATA_W-1:0] sat(input logic signed [W-1:0] v);
        logic [GUARD:0] top;
        top = v[W-1:DATA_W-1];
        return (&top || ~|top) ? v[DATA_W-1:0] : {v[W-1], {(DATA_W-1){~v[W-1]}}};
    endfunction

    assign x_ext = {{GUARD{x_i[DATA_W-1]}}, x_i};
    assign y_ext = {{GUARD{y_i[DATA_W-1]}}, y_i};
    // Pre-negation moves the vector into the right half-plane, where the micro-rotations converge.
    assign pre   = mode_i ? dir_i[ITER] : x_i[DATA_W-1];
    assign d     = mode_q ? dir_q[cnt_q] : ~y_q[W-1];
    assign x_sh  = x_q >>> cnt_q;
    assign y_sh  = y_q >>> cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: if (in_valid_i) begin
                state_d = RUN;
                cnt_d   = '0;
                mode_d  = mode_i;
                x_d     = pre ? -x_ext : x_ext;
                y_d     = pre ? -y_ext : y_ext;
                dir_d   = mode_i ? dir_i : {pre, {ITER{1'b0}}};
            end
            RUN: begin
                x_d   = d ? x_q + y_sh : x_q - y_sh;
                y_d   = d ? y_q - x_sh : y_q + x_sh;
                cnt_d = cnt_q + 1'b1;
                if (!mode_q) dir_d[cnt_q] = d;
                if (cnt_q == CW'(ITER - 1)) state_d = DONE;
            end
            DONE: if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            dir_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready_o  = state_q == IDLE;
    assign out_valid_o = state_q == DONE;
    assign x_o         = sat(x_q);
    assign y_o         = sat(y_q);
    assign dir_o       = dir_q;
endmodule

// File: tb/tb_cordic_vec_iter.sv
// tb_cordic_vec_iter: directed and randomised operands checked against an integer CORDIC model and hand-computed values.
module tb_cordic_vec_iter;
    localparam int ITER = 12;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid_i, in_ready_o, mode_i, out_valid_o, out_ready_i;
    logic signed [16:0] x_i, y_i, x_o, y_o;
    logic [12:0]        dir_i, dir_o;

    cordic_vec_iter dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .mode_i(mode_i), .x_i(x_i), .y_i(y_i), .dir_i(dir_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .x_o(x_o), .y_o(y_o), .dir_o(dir_o)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y; logic [12:0] d; int acc;} exp_t;
    exp_t        exp_q[$];
    int          cyc = 0, checks = 0, errors = 0, last_acc = 0;
    int          last_x, last_y;
    logic [12:0] last_dir, dv;
    bit          fresh = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Plain integer CORDIC: the full rotation sequence as a loop on unbounded ints, then clamp.
    function automatic void model(input logic m, input int xi, input int yi, input logic [12:0] di,
                                  output int xo, output int yo, output logic [12:0] dq);
        int x, y, t;
        logic p, d;
        p  = m ? di[12] : (xi < 0);
        x  = p ? -xi : xi;
        y  = p ? -yi : yi;
        dq = m ? di : {p, 12'b0};
        for (int i = 0; i < ITER; i++) begin
            d = m ? di[i] : (y >= 0);
            t = x;
            x = d ? x + (y >>> i) : x - (y >>> i);
            y = d ? y - (t >>> i) : y + (t >>> i);
            if (!m) dq[i] = d;
        end
        xo = x > 65535 ? 65535 : (x < -65536 ? -65536 : x);
        yo = y > 65535 ? 65535 : (y < -65536 ? -65536 : y);
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                chk("x_out", int'(x_o), exp_q[0].x);
                chk("y_out", int'(y_o), exp_q[0].y);
                chk("dir_out", int'(dir_o), int'(exp_q[0].d));
                chk("in_ready_in_done", int'(in_ready_o), 0);
                if (fresh) chk("latency", cyc - exp_q[0].acc, ITER);
                fresh    = 1'b0;
                last_x   = int'(x_o);
                last_y   = int'(y_o);
                last_dir = dir_o;
                if (out_ready_i) begin
                    void'(exp_q.pop_front());
                    fresh = 1'b1;
                end
            end
        end
    end

    task automatic send(input logic m, input int x, input int y, input logic [12:0] d);
        exp_t e;
        logic rdy;
        int   n = 0;
        in_valid_i = 1'b1;
        mode_i     = m;
        x_i        = x[16:0];
        y_i        = y[16:0];
        dir_i      = d;
        do begin
            @(negedge clk);
            rdy = in_ready_o;
            @(posedge clk);
            n++;
        end while (!rdy && n < 100);
        #1;
        in_valid_i = 1'b0;
        if (!rdy) begin
            chk("accept_timeout", 0, 1);
        end else begin
            model(m, x, y, d, e.x, e.y, e.d);
            e.acc    = cyc;
            last_acc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int mx, my, n, prev;
        logic [12:0] md;
        rst_n = 1'b0; in_valid_i = 1'b0; mode_i = 1'b0; x_i = '0; y_i = '0; dir_i = '0; out_ready_i = 1'b1;
        #12;
        chk("rst_in_ready", int'(in_ready_o), 1);
        chk("rst_out_valid", int'(out_valid_o), 0);
        chk("rst_x", int'(x_o), 0);
        chk("rst_y", int'(y_o), 0);
        chk("rst_dir", int'(dir_o), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        model(1'b0, 3000, 4000, 13'h0, mx, my, md);
        chk_rng("model_vec_x", mx, 8230, 8238);
        chk_rng("model_vec_y", my, -4, 4);
        send(1'b0, 3000, 4000, 13'h0); drain();
        chk_rng("vec_x", last_x, 8230, 8238);
        chk_rng("vec_y", last_y, -4, 4);
        chk("vec_pre", int'(last_dir[12]), 0);
        dv = last_dir;

        send(1'b1, 1000, 0, dv); drain();
        chk_rng("rot_x", last_x, 984, 992);
        chk_rng("rot_y", last_y, -1321, -1313);

        send(1'b0, -3000, 0, 13'h0); drain();
        chk("neg_pre", int'(last_dir[12]), 1);
        chk_rng("neg_x", last_x, 4936, 4944);
        chk_rng("neg_y", last_y, -4, 4);

        send(1'b0, 65535, 65535, 13'h0); drain();
        chk("sat_x", last_x, 65535);

        send(1'b0, -65536, 0, 13'h0); drain();
        chk("minneg_x", last_x, 65535);
        chk("minneg_pre", int'(last_dir[12]), 1);

        send(1'b0, 0, 0, 13'h0); drain();
        chk("zero_x", last_x, 0);
        chk("zero_y", last_y, 0);
        chk("zero_dir", int'(last_dir), 'h0FFF);

        prev = 0;
        for (int k = 0; k < 6; k++) begin
            mx = int'($urandom_range(0, 131071)) - 65536;
            my = int'($urandom_range(0, 131071)) - 65536;
            send(k[0], mx, my, 13'($urandom));
            if (k > 0) chk("throughput", last_acc - prev, ITER + 2);
            prev = last_acc;
        end
        drain();

        out_ready_i = 1'b0;
        send(1'b0, -1234, 5678, 13'h0);
        n = 0;
        while (!out_valid_o && n < 50) begin @(negedge clk); n++; end
        chk("bp_valid_seen", int'(out_valid_o), 1);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            in_valid_i = ~in_valid_i;
            x_i = 17'sd777; y_i = 17'sd333; mode_i = 1'b0;
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready_o), 0);
            chk("bp_out_valid", int'(out_valid_o), 1);
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", int'(out_valid_o), 0);
        chk("bp_release_ready", int'(in_ready_o), 1);
        chk("bp_queue_empty", exp_q.size(), 0);

        send(1'b0, 20000, -15000, 13'h0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(out_valid_o), 0);
        chk("mid_rst_x", int'(x_o), 0);
        chk("mid_rst_y", int'(y_o), 0);
        chk("mid_rst_ready", int'(in_ready_o), 1);
        exp_q.delete();
        fresh = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        send(1'b0, -4000, -3000, 13'h0); drain();
        chk_rng("post_rst_x", last_x, 8230, 8238);
        chk("post_rst_pre", int'(last_dir[12]), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
